// File: rtl/cond_pkg.sv
// Shared types for the condition unit: condition codes, flag layout, FSM states.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BLOCK = 1'b1
  } it_state_e;

  // Merge ALU flags into the current flags; we[1] selects N,Z and we[0] selects C,V.
  function automatic flags_t merge_flags(flags_t cur, flags_t alu, logic [1:0] we);
    flags_t r;
    r.n = we[1] ? alu.n : cur.n;
    r.z = we[1] ? alu.z : cur.z;
    r.c = we[0] ? alu.c : cur.c;
    r.v = we[0] ? alu.v : cur.v;
    return r;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: condition code x flags -> pass/fail.
module cond_eval
  import cond_pkg::*;
(
  input  cond_e  cond,
  input  flags_t flags,
  output logic   condex,
  output logic   undef_c
);

  // Decode the condition against the flags; NV never passes and flags an error.
  always_comb begin
    condex  = 1'b0;
    undef_c = 1'b0;
    case (cond)
      EQ: condex = flags.z;
      NE: condex = ~flags.z;
      CS: condex = flags.c;
      CC: condex = ~flags.c;
      MI: condex = flags.n;
      PL: condex = ~flags.n;
      VS: condex = flags.v;
      VC: condex = ~flags.v;
      HI: condex = flags.c & ~flags.z;
      LS: condex = ~flags.c | flags.z;
      GE: condex = (flags.n == flags.v);
      LT: condex = (flags.n != flags.v);
      GT: condex = ~flags.z & (flags.n == flags.v);
      LE: condex = flags.z | (flags.n != flags.v);
      AL: condex = 1'b1;
      default: begin
        condex  = 1'b0;
        undef_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cond_unit_pipe.sv
// Condition unit: NZCV register, saved-flag banks, conditional-block FSM and
// gating of the datapath write/branch enables.
module cond_unit_pipe
  import cond_pkg::*;
#(
  parameter int          NUM_BANKS   = 2,
  parameter int          IT_MAX      = 4,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000,
  localparam int         LEN_W       = $clog2(IT_MAX + 1),
  localparam int         BS_W        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             it_start,
  input  logic [3:0]       it_cond,
  input  logic [LEN_W-1:0] it_len,
  input  logic             save,
  input  logic             restore,
  input  logic [BS_W-1:0]  bank_sel,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             storedCarry,
  output logic             it_active,
  output logic             undef
);

  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] CNT_MAX  = LEN_W'(IT_MAX);

  flags_t            flags_q, flags_d, flags_wr_s, sel_bank_s;
  flags_t            bank_q [NUM_BANKS];
  flags_t            bank_d [NUM_BANKS];
  it_state_e         state_q;
  logic [LEN_W-1:0]  cnt_q;
  cond_e             it_cond_q;
  logic              undef_q, undef_d;

  logic              acc_s, in_block_s, condex_s, undef_c_s, fire_s;
  logic              bank_ok_s, do_bank_s, len_over_s;
  logic [LEN_W-1:0]  len_clamped_s;
  cond_e             eff_cond_s;

  // Inside a block the shared condition overrides the instruction's own field.
  assign acc_s      = valid_in & ~stall & ~flush & reset;
  assign in_block_s = (state_q == BLOCK);
  assign eff_cond_s = in_block_s ? it_cond_q : cond_e'(Cond);

  cond_eval u_cond_eval (
    .cond    (eff_cond_s),
    .flags   (flags_q),
    .condex  (condex_s),
    .undef_c (undef_c_s)
  );

  // Any it_start is a no-op: either it opens a block or it is illegal inside one.
  assign fire_s        = acc_s & condex_s & ~it_start;
  assign bank_ok_s     = (int'(bank_sel) < NUM_BANKS);
  assign do_bank_s     = acc_s & bank_ok_s;
  assign len_over_s    = (int'(it_len) > IT_MAX);
  assign len_clamped_s = len_over_s ? CNT_MAX : it_len;

  assign PCSrc       = PCS  & fire_s;
  assign RegWrite    = RegW & fire_s;
  assign MemWrite    = MemW & fire_s;
  assign Flags       = flags_q;
  assign storedCarry = flags_q.c;
  assign it_active   = in_block_s;
  assign undef       = undef_q;

  // Select the addressed bank without ever indexing past the array.
  always_comb begin
    sel_bank_s = flags_t'(4'b0000);
    for (int i = 0; i < NUM_BANKS; i++) begin
      sel_bank_s = (int'(bank_sel) == i) ? bank_q[i] : sel_bank_s;
    end
  end

  // Next flags: restore beats the ALU write; save+restore together freezes the flags.
  always_comb begin
    flags_wr_s = merge_flags(flags_q, flags_t'(ALUFlags), FlagW & {2{fire_s}});
    if (do_bank_s & save & restore) begin
      flags_d = flags_q;
    end else if (do_bank_s & restore) begin
      flags_d = sel_bank_s;
    end else begin
      flags_d = flags_wr_s;
    end
  end

  // Next bank contents: a save captures the flags as they were before this edge.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_d[i] = (do_bank_s & save & ~restore & (int'(bank_sel) == i)) ? flags_q : bank_q[i];
    end
  end

  // Error pulse for NV, a bad bank index, an over-long block or a nested block start.
  always_comb begin
    undef_d = acc_s & (undef_c_s
                       | ((save | restore) & ~bank_ok_s)
                       | (it_start & (in_block_s | len_over_s)));
  end

  // Flag register, saved banks and the registered error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= flags_t'(RESET_FLAGS);
      undef_q <= 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_q[i] <= flags_t'(4'b0000);
      end
    end else begin
      flags_q <= flags_d;
      undef_q <= undef_d;
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  // Conditional-block FSM: flush aborts, each accepted instruction consumes one slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      it_cond_q <= AL;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else if (acc_s) begin
      case (state_q)
        IDLE: begin
          if (it_start && (it_len != CNT_ZERO)) begin
            state_q   <= BLOCK;
            cnt_q     <= len_clamped_s;
            it_cond_q <= cond_e'(it_cond);
          end
        end
        BLOCK: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Self-checking bench for cond_unit_pipe: directed table, hand sequences and
// randomized traffic against a behavioural model of the condition unit.
module tb_cond_unit_pipe;

  localparam int         NB    = 3;
  localparam int         ITM   = 4;
  localparam logic [3:0] RFLG  = 4'b0101;

  localparam logic [3:0] C_EQ = 4'b0000, C_NE = 4'b0001, C_HI = 4'b1000,
                         C_LS = 4'b1001, C_AL = 4'b1110, C_NV = 4'b1111;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in, stall, flush, PCS, RegW, MemW, it_start, save, restore;
  logic [3:0] Cond, ALUFlags, it_cond;
  logic [1:0] FlagW, bank_sel;
  logic [2:0] it_len;
  logic       PCSrc, RegWrite, MemWrite, storedCarry, it_active, undef;
  logic [3:0] Flags;

  cond_unit_pipe #(.NUM_BANKS(NB), .IT_MAX(ITM), .RESET_FLAGS(RFLG)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .it_start(it_start), .it_cond(it_cond), .it_len(it_len),
    .save(save), .restore(restore), .bank_sel(bank_sel), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags),
    .storedCarry(storedCarry), .it_active(it_active), .undef(undef)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v, st, fl;
    logic [3:0] cond, alu;
    logic [1:0] fw;
    logic       pcs, regw, memw, its;
    logic [3:0] itc;
    logic [2:0] itl;
    logic       sv, rs;
    logic [1:0] bs;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [2:0] exp_en;
    logic [3:0] exp_flags;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [3:0] m_flags;
  logic [3:0] m_bank [NB];
  bit         m_blk;
  int         m_rem;
  logic [3:0] m_bcond;
  bit         m_undef;

  // ARM rule: bits [3:1] pick a predicate, bit 0 inverts it; 1110 always, 1111 never.
  function automatic bit cond_true(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'd15) return 1'b0;
    if (c == 4'd14) return 1'b1;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy & ~z;
      3'd5: r = (n == v);
      default: r = ~z & (n == v);
    endcase
    return r ^ c[0];
  endfunction

  function automatic stim_t ins(logic [3:0] c, logic [3:0] alu, logic [1:0] fw, logic [2:0] en3);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.cond = c; s.alu = alu; s.fw = fw;
    s.pcs = en3[2]; s.regw = en3[1]; s.memw = en3[0];
    return s;
  endfunction

  task automatic drive(input stim_t s);
    valid_in = s.v; stall = s.st; flush = s.fl; Cond = s.cond; ALUFlags = s.alu;
    FlagW = s.fw; PCS = s.pcs; RegW = s.regw; MemW = s.memw; it_start = s.its;
    it_cond = s.itc; it_len = s.itl; save = s.sv; restore = s.rs; bank_sel = s.bs;
  endtask

  task automatic model_reset();
    m_flags = RFLG;
    for (int i = 0; i < NB; i++) m_bank[i] = 4'b0000;
    m_blk = 1'b0; m_rem = 0; m_bcond = C_AL; m_undef = 1'b0;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // One clocked instruction: compare all outputs with the model, clock, advance the model.
  // got = {PCSrc,RegWrite,MemWrite,Flags,storedCarry,it_active,undef}
  task automatic step(input stim_t s, output logic [9:0] got);
    logic [9:0] exp;
    logic [3:0] eff, nf;
    bit acc, fire, badb;
    drive(s);
    #2;
    acc  = s.v & ~s.st & ~s.fl;
    eff  = m_blk ? m_bcond : s.cond;
    fire = acc & cond_true(eff, m_flags) & ~s.its;
    exp  = {s.pcs & fire, s.regw & fire, s.memw & fire, m_flags, m_flags[1], m_blk, m_undef};
    got  = {PCSrc, RegWrite, MemWrite, Flags, storedCarry, it_active, undef};
    check("step", {6'd0, got}, {6'd0, exp});
    @(posedge clk);
    #1;
    badb    = (int'(s.bs) >= NB);
    m_undef = acc & ((eff == 4'd15) | ((s.sv | s.rs) & badb)
                     | (s.its & (m_blk | (int'(s.itl) > ITM))));
    nf = m_flags;
    if (fire & s.fw[1]) nf[3:2] = s.alu[3:2];
    if (fire & s.fw[0]) nf[1:0] = s.alu[1:0];
    if (acc && !badb) begin
      if (s.sv && s.rs) nf = m_flags;
      else if (s.sv) m_bank[s.bs] = m_flags;
      else if (s.rs) nf = m_bank[s.bs];
    end
    m_flags = nf;
    if (s.fl) begin
      m_blk = 1'b0; m_rem = 0;
    end else if (acc) begin
      if (m_blk) begin
        m_rem--;
        if (m_rem == 0) m_blk = 1'b0;
      end else if (s.its && s.itl != 3'd0) begin
        m_blk = 1'b1;
        m_rem = (int'(s.itl) > ITM) ? ITM : int'(s.itl);
        m_bcond = s.itc;
      end
    end
  endtask

  vec_t       tbl [14];
  stim_t      s;
  logic [9:0] g;
  int         act;

  initial begin
    // ---------------- reset ----------------
    reset = 1'b0;
    drive(ins(C_AL, 4'b1111, 2'b11, 3'b111));
    model_reset();
    @(posedge clk); @(posedge clk); #3;
    check("reset_state", {6'd0, PCSrc, RegWrite, MemWrite, Flags, storedCarry, it_active, undef},
          {6'd0, 3'b000, RFLG, RFLG[1], 1'b0, 1'b0});
    @(posedge clk); #1;
    reset = 1'b1;

    // ---------------- directed table ----------------
    tbl[0]  = '{ins(C_AL, 4'b0100, 2'b11, 3'b010), 3'b010, 4'b0100};
    tbl[1]  = '{ins(C_EQ, 4'b0000, 2'b00, 3'b010), 3'b010, 4'b0100};
    tbl[2]  = '{ins(C_NE, 4'b1111, 2'b11, 3'b011), 3'b000, 4'b0100};
    tbl[3]  = '{ins(C_AL, 4'b0000, 2'b11, 3'b100), 3'b100, 4'b0000};
    tbl[4]  = '{ins(C_AL, 4'b1010, 2'b10, 3'b000), 3'b000, 4'b1000};
    tbl[5]  = '{ins(C_AL, 4'b1010, 2'b01, 3'b000), 3'b000, 4'b1010};
    tbl[6]  = '{ins(C_AL, 4'b0010, 2'b11, 3'b000), 3'b000, 4'b0010};
    tbl[7]  = '{ins(C_AL, 4'b1101, 2'b11, 3'b000), 3'b000, 4'b1101};
    tbl[7].s.sv = 1'b1; tbl[7].s.bs = 2'd1;
    tbl[8]  = '{ins(C_AL, 4'b0000, 2'b11, 3'b000), 3'b000, 4'b0010};
    tbl[8].s.rs = 1'b1; tbl[8].s.bs = 2'd1;
    tbl[9]  = '{ins(C_AL, 4'b1111, 2'b11, 3'b010), 3'b000, 4'b0010};
    tbl[9].s.st = 1'b1;
    tbl[10] = '{ins(C_AL, 4'b1111, 2'b11, 3'b010), 3'b000, 4'b0010};
    tbl[10].s.v = 1'b0;
    tbl[11] = '{ins(C_AL, 4'b1111, 2'b11, 3'b010), 3'b000, 4'b0010};
    tbl[11].s.fl = 1'b1;
    tbl[12] = '{ins(C_HI, 4'b0000, 2'b00, 3'b001), 3'b001, 4'b0010};
    tbl[13] = '{ins(C_LS, 4'b0000, 2'b00, 3'b001), 3'b000, 4'b0010};
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].s, g);
      check($sformatf("tbl%0d_en", i), {13'd0, g[9:7]}, {13'd0, tbl[i].exp_en});
      check($sformatf("tbl%0d_flags", i), {11'd0, Flags, storedCarry},
            {11'd0, tbl[i].exp_flags, tbl[i].exp_flags[1]});
    end

    // ---------------- conditional block, EQ with Z=1 ----------------
    step(ins(C_AL, 4'b0100, 2'b10, 3'b000), g);
    s = ins(C_NE, 4'b0000, 2'b00, 3'b010);
    s.its = 1'b1; s.itc = C_EQ; s.itl = 3'd3;
    step(s, g);
    check("it_open_en", {13'd0, g[9:7]}, 16'd0);
    act = 0;
    for (int i = 0; i < 3; i++) begin
      step(ins(C_NE, 4'b0000, 2'b00, 3'b010), g);
      check("it_body_regw", {15'd0, g[8]}, 16'd1);
      act += int'(g[1]);
    end
    step(ins(C_NE, 4'b0000, 2'b00, 3'b010), g);
    check("it_after_regw", {15'd0, g[8]}, 16'd0);
    act += int'(g[1]);
    check("it_active_cycles", 16'(act), 16'd3);

    // ---------------- stall then flush inside a block ----------------
    s = ins(C_AL, 4'b0000, 2'b00, 3'b000);
    s.its = 1'b1; s.itc = C_NE; s.itl = 3'd3;
    step(s, g);
    s = ins(C_AL, 4'b0000, 2'b00, 3'b010); s.st = 1'b1;
    step(s, g);
    step(s, g);
    check("stall_hold_active", {15'd0, it_active}, 16'd1);
    s = ins(C_AL, 4'b0000, 2'b00, 3'b010); s.fl = 1'b1;
    step(s, g);
    check("flush_active", {15'd0, it_active}, 16'd0);
    step(ins(C_EQ, 4'b0000, 2'b00, 3'b010), g);
    check("own_cond_after_flush", {13'd0, g[9:7]}, 16'd2);

    // ---------------- undefined encodings and bad bank ----------------
    step(ins(C_NV, 4'b1111, 2'b11, 3'b111), g);
    check("nv_enables", {13'd0, g[9:7]}, 16'd0);
    check("nv_undef", {15'd0, undef}, 16'd1);
    step(ins(C_AL, 4'b0000, 2'b00, 3'b000), g);
    check("nv_undef_pulse", {15'd0, undef}, 16'd0);
    s = ins(C_AL, 4'b0000, 2'b00, 3'b000); s.sv = 1'b1; s.bs = 2'(NB);
    step(s, g);
    check("bad_bank_undef", {15'd0, undef}, 16'd1);

    // ---------------- over-long block is clamped ----------------
    s = ins(C_AL, 4'b0000, 2'b00, 3'b000);
    s.its = 1'b1; s.itc = C_AL; s.itl = 3'd7;
    step(s, g);
    check("clamp_undef", {15'd0, undef}, 16'd1);
    act = 0;
    for (int i = 0; i < 6; i++) begin
      step(ins(C_AL, 4'b0000, 2'b00, 3'b000), g);
      act += int'(g[1]);
    end
    check("clamp_cycles", 16'(act), 16'(ITM));

    // ---------------- reset mid-block ----------------
    step(ins(C_AL, 4'b1011, 2'b11, 3'b000), g);
    s = ins(C_AL, 4'b0000, 2'b00, 3'b000);
    s.its = 1'b1; s.itc = C_AL; s.itl = 3'd3;
    step(s, g);
    step(ins(C_AL, 4'b0000, 2'b00, 3'b000), g);
    drive(ins(C_AL, 4'b1111, 2'b11, 3'b111));
    reset = 1'b0;
    #2;
    check("midreset_state", {6'd0, PCSrc, RegWrite, MemWrite, Flags, storedCarry, it_active, undef},
          {6'd0, 3'b000, RFLG, RFLG[1], 1'b0, 1'b0});
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 800; i++) begin
      s = '0;
      s.v    = ($urandom_range(0, 7) != 0);
      s.st   = ($urandom_range(0, 7) == 0);
      s.fl   = ($urandom_range(0, 15) == 0);
      s.cond = ($urandom_range(0, 19) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      s.alu  = 4'($urandom);
      s.fw   = 2'($urandom);
      s.pcs  = 1'($urandom); s.regw = 1'($urandom); s.memw = 1'($urandom);
      s.its  = ($urandom_range(0, 9) == 0);
      s.itc  = 4'($urandom_range(0, 14));
      s.itl  = 3'($urandom);
      s.sv   = ($urandom_range(0, 7) == 0);
      s.rs   = ($urandom_range(0, 7) == 0);
      s.bs   = 2'($urandom);
      step(s, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
